// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line idle level and FSM state encodings.
// Used by both uart_rx and uart_tx so the two ends agree on naming and framing.
package uart_pkg;

    localparam int       DATA_BITS = 8;
    localparam logic     LINE_IDLE = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP,
        BREAK = ST_BREAK
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2-cycle latency,
// no backpressure. Reset loads RESET_VAL so an idle line does not look like an edge.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q_o  <= RESET_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: byte out with a one-cycle v_o pulse ~half a bit after the stop bit starts; no backpressure.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit (needs CLKS_PER_BIT >= 4).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] d_o,
    output logic                 v_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 sample_bit;
    uart_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n, cnt_wrap;
    logic [2:0]           bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, d_n;
    logic                 v_n, ferr_n, at_sample;

    uart_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be >= 4 with majority sampling");
    end

    localparam logic [CW-1:0] CNT_SAMPLE = CW'(HALF);

    // hist[1] holds rx_s from cnt==HALF-2, hist[0] from HALF-1; vote lands at cnt==HALF.
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (reset) hist <= {2{LINE_IDLE}};
        else       hist <= {hist[0], rx_s};
    end

    assign sample_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be >= 2");
    end

    localparam logic [CW-1:0] CNT_SAMPLE = CW'(HALF - 1);

    assign sample_bit = rx_s;
`endif

    assign at_sample = (cnt == CNT_SAMPLE);
    assign cnt_wrap  = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    assign busy_o    = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        d_n     = d_o;
        v_n     = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_s != LINE_IDLE) state_n = START;
            end
            START: begin
                // Wrapping keeps counting so every later sample is one full bit period apart.
                cnt_n = cnt_wrap;
                if (at_sample) begin
                    if (sample_bit == LINE_IDLE) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
            end
            DATA: begin
                cnt_n = cnt_wrap;
                if (at_sample) begin
                    shreg_n[bit_idx] = sample_bit;
                    if (bit_idx == BIT_LAST) state_n = STOP;
                    else                     bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                cnt_n = cnt_wrap;
                if (at_sample) begin
                    d_n   = shreg;
                    cnt_n = '0;
                    if (sample_bit == LINE_IDLE) begin
                        v_n     = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s == LINE_IDLE) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            d_o         <= '0;
            v_o         <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_n;
            shreg       <= shreg_n;
            d_o         <= d_n;
            v_o         <= v_n;
            frame_err_o <= ferr_n;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: two instances (CLKS_PER_BIT 4 and 8) fed by a bit-level line driver.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx4, rx8;
    logic [7:0] d4, d8;
    logic       v4, v8, fe4, fe8, busy4, busy8;

    int errors = 0;
    int checks = 0;

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .rx_i(rx4),
        .d_o(d4), .v_o(v4), .frame_err_o(fe4), .busy_o(busy4)
    );

    uart_rx #(.CLKS_PER_BIT(8)) dut8 (
        .clk(clk), .reset(reset), .rx_i(rx8),
        .d_o(d8), .v_o(v8), .frame_err_o(fe8), .busy_o(busy8)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge.
    int         cyc = 0;
    int         v4_n = 0, fe4_n = 0, v8_n = 0, fe8_n = 0, busy8_n = 0, both_n = 0;
    int         v4_cyc = 0, v4_cyc_prev = 0, b4_fall = 0;
    logic [7:0] v4_d = 8'h00, v4_d_prev = 8'h00, v8_d = 8'h00;
    logic       busy4_q = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (v4) begin
            v4_n        = v4_n + 1;
            v4_d_prev   = v4_d;
            v4_d        = d4;
            v4_cyc_prev = v4_cyc;
            v4_cyc      = cyc;
        end
        if (fe4) fe4_n = fe4_n + 1;
        if (v8) begin
            v8_n = v8_n + 1;
            v8_d = d8;
        end
        if (fe8)   fe8_n   = fe8_n + 1;
        if (busy8) busy8_n = busy8_n + 1;
        if ((v4 && fe4) || (v8 && fe8)) both_n = both_n + 1;
        if (busy4_q && !busy4) b4_fall = cyc;
        busy4_q = busy4;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives nslots bit slots (start, 8 data LSB first, stop) of a frame; one data bit may be glitched.
    task automatic send(input int sel, input logic [7:0] b, input logic stop_bit,
                        input int gbit, input int goff, input int nslots);
        int         cpb;
        logic [9:0] fr;
        logic       lv;
        cpb = (sel == 4) ? 4 : 8;
        fr  = {stop_bit, b, 1'b0};
        for (int s = 0; s < nslots; s++) begin
            for (int k = 0; k < cpb; k++) begin
                @(negedge clk);
                lv = fr[s];
                if (s == gbit + 1 && k == goff) lv = ~lv;
                if (sel == 4) rx4 = lv;
                else          rx8 = lv;
            end
        end
    endtask

    task automatic hold(input int sel, input logic val, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (sel == 4) rx4 = val;
            else          rx8 = val;
        end
    endtask

    int         v_base, fe_base, b_base;
    logic [7:0] glitch_exp;

    initial begin
        reset = 1'b1;
        rx4   = 1'b1;
        rx8   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_d4", {24'h0, d4}, 32'h00);
        check("rst_v4", {31'h0, v4}, 32'h0);
        check("rst_fe4", {31'h0, fe4}, 32'h0);
        check("rst_busy4", {31'h0, busy4}, 32'h0);
        check("rst_d8", {24'h0, d8}, 32'h00);
        check("rst_busy8", {31'h0, busy8}, 32'h0);
        reset = 1'b0;
        hold(4, 1'b1, 4);

        // Single frame 0xA5 at 4 clocks/bit.
        v_base  = v4_n;
        fe_base = fe4_n;
        send(4, 8'hA5, 1'b1, -1, 0, 10);
        hold(4, 1'b1, 12);
        check("loop_vcount", v4_n - v_base, 1);
        check("loop_data", {24'h0, v4_d}, 32'hA5);
        check("loop_fe", fe4_n - fe_base, 0);
        check("loop_busy_fall", ((b4_fall - v4_cyc) >= 0) && ((b4_fall - v4_cyc) <= 2), 1);
        check("loop_hold_d", {24'h0, d4}, 32'hA5);

        // Back-to-back 0x00, 0xFF with no idle gap.
        v_base = v4_n;
        send(4, 8'h00, 1'b1, -1, 0, 10);
        send(4, 8'hFF, 1'b1, -1, 0, 10);
        hold(4, 1'b1, 12);
        check("b2b_vcount", v4_n - v_base, 2);
        check("b2b_first", {24'h0, v4_d_prev}, 32'h00);
        check("b2b_second", {24'h0, v4_d}, 32'hFF);
        check("b2b_spacing", v4_cyc - v4_cyc_prev, 40);

        // One-cycle low pulse at 8 clocks/bit is a false start.
        v_base  = v8_n;
        fe_base = fe8_n;
        b_base  = busy8_n;
        hold(8, 1'b0, 1);
        hold(8, 1'b1, 20);
        check("fstart_v", v8_n - v_base, 0);
        check("fstart_fe", fe8_n - fe_base, 0);
        check("fstart_busy_len", ((busy8_n - b_base) > 0) && ((busy8_n - b_base) < 8), 1);
        check("fstart_idle", {31'h0, busy8}, 32'h0);

        // Framing error: 0x3C with low stop bit, then the line held low (break).
        v_base  = v4_n;
        fe_base = fe4_n;
        send(4, 8'h3C, 1'b0, -1, 0, 10);
        hold(4, 1'b0, 40);
        check("ferr_count", fe4_n - fe_base, 1);
        check("ferr_no_v", v4_n - v_base, 0);
        check("ferr_data", {24'h0, d4}, 32'h3C);
        check("ferr_busy_held", {31'h0, busy4}, 32'h1);
        hold(4, 1'b1, 6);
        check("ferr_busy_release", {31'h0, busy4}, 32'h0);
        check("ferr_single", fe4_n - fe_base, 1);
        v_base = v4_n;
        send(4, 8'h81, 1'b1, -1, 0, 10);
        hold(4, 1'b1, 12);
        check("after_ferr_v", v4_n - v_base, 1);
        check("after_ferr_data", {24'h0, v4_d}, 32'h81);

        // Reset during data bit 3 of 0x5A, then a clean 0x12.
        v_base  = v4_n;
        fe_base = fe4_n;
        fork
            send(4, 8'h5A, 1'b1, -1, 0, 5);
            begin
                repeat (19) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("midrst_d", {24'h0, d4}, 32'h00);
                check("midrst_busy", {31'h0, busy4}, 32'h0);
                check("midrst_v", {31'h0, v4}, 32'h0);
            end
        join
        hold(4, 1'b1, 60);
        check("midrst_no_v", v4_n - v_base, 0);
        check("midrst_no_fe", fe4_n - fe_base, 0);
        v_base = v4_n;
        send(4, 8'h12, 1'b1, -1, 0, 10);
        hold(4, 1'b1, 12);
        check("post_rst_v", v4_n - v_base, 1);
        check("post_rst_data", {24'h0, v4_d}, 32'h12);

        // Inverted one-cycle glitch at the middle of bit 2 of 0xF0.
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'hF0;
`else
        glitch_exp = 8'hF4;
`endif
        v_base = v8_n;
        send(8, 8'hF0, 1'b1, 2, 4, 10);
        hold(8, 1'b1, 16);
        check("glitch_v", v8_n - v_base, 1);
        check("glitch_data", {24'h0, v8_d}, {24'h0, glitch_exp});

        check("pulse_exclusive", both_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
